// File: rtl/lm_cluster.sv
// lm_cluster: CH configurable logic cells, each a 2^SEL_W:1 mux (data or LUT)
// with optional output register, configured by a serial shadow-chain bitstream.
// Ports: clk, clr (async high reset); cfg_start/cfg_valid/cfg_bit/cfg_ready/
// cfg_done configuration handshake; en register enable; d, sel cell inputs;
// out cell outputs.
module lm_cluster #(
   parameter int SEL_W = 2,
   parameter int CH    = 4
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    cfg_start,
   input  logic                    cfg_valid,
   input  logic                    cfg_bit,
   output logic                    cfg_ready,
   output logic                    cfg_done,
   input  logic                    en,
   input  logic [CH*(2**SEL_W)-1:0] d,
   input  logic [CH*SEL_W-1:0]     sel,
   output logic [CH-1:0]           out
);

   localparam int N        = 2**SEL_W;
   localparam int W        = N + 2;
   localparam int CFG_BITS = CH * W;
   localparam int CW       = $clog2(CFG_BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(CFG_BITS - 1);

   typedef enum logic [1:0] {
      UNCFG,
      LOAD,
      RUN
   } state_t;

   state_t                state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [CFG_BITS-1:0]   shadow, shadow_n, act;
   logic                  live;
   logic                  accept, commit;
   logic [CH-1:0]         m, q;

   assign shadow_n  = {shadow[CFG_BITS-2:0], cfg_bit};
   assign cfg_ready = (state == LOAD);
   // Active config stays valid through a reload, so done tracks it, not state.
   assign cfg_done  = live;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= UNCFG;
      end else begin
         state <= state_n;
      end
   end

   // cfg_start during LOAD takes priority over a bit presented that cycle.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      commit  = 1'b0;
      unique case (state)
         UNCFG: begin
            if (cfg_start) begin
               state_n = LOAD;
               cnt_n   = '0;
            end
         end
         LOAD: begin
            if (cfg_start) begin
               cnt_n = '0;
            end else if (cfg_valid) begin
               accept = 1'b1;
               if (cnt == LAST) begin
                  commit  = 1'b1;
                  cnt_n   = '0;
                  state_n = RUN;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         RUN: begin
            if (cfg_start) begin
               state_n = LOAD;
               cnt_n   = '0;
            end
         end
         default: state_n = UNCFG;
      endcase
   end

   // Commit copies the shadow including the bit accepted on this edge.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt    <= '0;
         shadow <= '0;
         act    <= '0;
         live   <= 1'b0;
      end else begin
         cnt <= cnt_n;
         if (accept) begin
            shadow <= shadow_n;
         end
         if (commit) begin
            act  <= shadow_n;
            live <= 1'b1;
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_cell
      logic [W-1:0]     cv;
      logic [N-1:0]     dc, lut;
      logic [SEL_W-1:0] sc;

      assign cv  = act[c*W +: W];
      assign lut = cv[W-1:2];
      assign dc  = d[c*N +: N];
      assign sc  = sel[c*SEL_W +: SEL_W];
      assign m[c] = cv[1] ? lut[sc] : dc[sc];

      always_ff @(posedge clk or posedge clr) begin
         if (clr) begin
            q[c] <= 1'b0;
         end else if (live && en) begin
            q[c] <= m[c];
         end
      end

      assign out[c] = live ? (cv[0] ? m[c] : q[c]) : 1'b0;
   end

endmodule

// File: tb/tb_lm_cluster.sv
// tb_lm_cluster: randomized bench for lm_cluster against a behavioural model
// built from bit queues and per-cell config fields.
module tb_lm_cluster;

   localparam int SEL_W = 2;
   localparam int CH    = 4;
   localparam int N     = 4;
   localparam int W     = 6;
   localparam int CB    = 24;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          cfg_start = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_bit = 1'b0;
   logic          cfg_ready, cfg_done;
   logic          en = 1'b0;
   logic [15:0]   d = '0;
   logic [7:0]    sel = '0;
   logic [3:0]    out;

   int errors = 0;
   int checks = 0;

   // model state
   bit            mload, mdone;
   logic [CB-1:0] mact;
   logic [3:0]    mq;
   bit            shq[$];

   lm_cluster #(.SEL_W(SEL_W), .CH(CH)) dut (
      .clk(clk), .clr(clr), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_bit(cfg_bit), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
      .en(en), .d(d), .sel(sel), .out(out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] mvec();
      logic [3:0] r;
      for (int c = 0; c < CH; c++) begin
         int s;
         s = int'(sel[c*SEL_W +: SEL_W]);
         if (mact[c*W+1]) r[c] = mact[c*W+2+s];
         else             r[c] = d[c*N+s];
      end
      return r;
   endfunction

   function automatic logic [3:0] eout();
      logic [3:0] m, r;
      m = mvec();
      for (int c = 0; c < CH; c++)
         r[c] = mdone ? (mact[c*W] ? m[c] : mq[c]) : 1'b0;
      return r;
   endfunction

   task automatic mreset();
      mload = 0; mdone = 0; mact = '0; mq = '0; shq.delete();
   endtask

   task automatic medge();
      logic [3:0] m;
      m = mvec();
      if (mdone && en) mq = m;
      if (mload) begin
         if (cfg_start) shq.delete();
         else if (cfg_valid) begin
            shq.push_back(cfg_bit);
            if (shq.size() == CB) begin
               for (int i = 0; i < CB; i++) mact[CB-1-i] = shq[i];
               mdone = 1; mload = 0; shq.delete();
            end
         end
      end else if (cfg_start) begin
         mload = 1; shq.delete();
      end
   endtask

   // check current outputs, then advance one clock edge
   task automatic step();
      #1;
      chk("out", 32'(out), 32'(eout()));
      chk("cfg_ready", 32'(cfg_ready), 32'(mload));
      chk("cfg_done", 32'(cfg_done), 32'(mdone));
      @(posedge clk);
      medge();
      @(negedge clk);
   endtask

   task automatic rnd_data();
      d   = 16'($urandom);
      sel = 8'($urandom);
      en  = 1'($urandom);
   endtask

   task automatic start();
      cfg_start = 1; step(); cfg_start = 0;
   endtask

   task automatic send(input logic [CB-1:0] v, input int hi, input int lo,
                       input bit stall, input bit rdat);
      for (int i = hi; i >= lo; i--) begin
         if (rdat) rnd_data();
         if (stall) begin
            cfg_valid = 0; cfg_bit = 1'($urandom); step();
         end
         cfg_valid = 1; cfg_bit = v[i]; step();
      end
      cfg_valid = 0;
   endtask

   task automatic pulse_clr();
      clr = 1; #1;
      mreset();
      chk("clr_out", 32'(out), 32'h0);
      chk("clr_ready", 32'(cfg_ready), 32'h0);
      chk("clr_done", 32'(cfg_done), 32'h0);
      #1 clr = 0;
   endtask

   initial begin
      logic [CB-1:0] v;
      mreset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_out", 32'(out), 32'h0);
      clr = 0;
      for (int i = 0; i < 6; i++) begin
         rnd_data(); step();
      end
      pulse_clr();
      for (int i = 0; i < 3; i++) begin
         rnd_data(); step();
      end

      // all cells data mux, registered
      start();
      send('0, CB-1, 0, 0, 0);
      chk("done_after_load", 32'(cfg_done), 32'h1);
      d = 16'h8421; sel = 8'b11_10_01_00; en = 1; step();
      #1 chk("mux_reg", 32'(out), 32'hF);
      d = 16'h0000; en = 0; step(); step();
      #1 chk("en_hold", 32'(out), 32'hF);

      // cell0 LUT AND, bypassed; loaded with stalls
      v = '0; v[5:0] = 6'b100011;
      start();
      send(v, CB-1, 0, 1, 0);
      d = 16'($urandom); sel = 8'b00_00_00_11; step();
      #1 chk("lut_11", 32'(out[0]), 32'h1);
      d = 16'hFFFF; sel = 8'b00_00_00_10; step();
      #1 chk("lut_10", 32'(out[0]), 32'h0);

      // partial reload aborted by reset
      start();
      send(24'($urandom), CB-1, CB-10, 0, 1);
      pulse_clr();
      rnd_data(); step();

      // random configs, reloads in RUN with live traffic
      for (int k = 0; k < 8; k++) begin
         v = 24'($urandom);
         start();
         send(v, CB-1, 0, k[0], 1);
         for (int i = 0; i < 10; i++) begin
            rnd_data(); step();
         end
      end

      // restart mid-load: needs a full 24 bits after restart
      v = 24'($urandom);
      start();
      send(24'($urandom), CB-1, CB-10, 0, 1);
      start();
      send(v, CB-1, 1, 0, 1);
      chk("no_commit_23", 32'(cfg_ready), 32'h1);
      send(v, 0, 0, 0, 1);
      chk("commit_24", 32'(cfg_ready), 32'h0);
      for (int i = 0; i < 12; i++) begin
         rnd_data(); step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
